// File: rtl/pool_pkg.sv
// Shared types and frame-size helpers for the pool/ReLU frame sequencer.
package pool_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int W_DEF   = 26;
    localparam int IN_PIX  = W_DEF * W_DEF;
    localparam int OUT_PIX = (W_DEF / 2) * (W_DEF / 2);

    function automatic int in_pix(input int w);
        return w * w;
    endfunction

    function automatic int out_pix(input int w);
        return (w / 2) * (w / 2);
    endfunction

endpackage

// File: rtl/pool_relu_sched.sv
// Frame sequencer for the 4-lane pool/ReLU datapath: gates conv pixels
// into the lanes, waits for pooled outputs, and clears the lanes per frame.
module pool_relu_sched
    import pool_pkg::*;
#(
    parameter int In_d_W    = 32,
    parameter int W         = W_DEF,
    parameter int FRM_W     = 8,
    parameter int DRAIN_MAX = 64
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic [FRM_W-1:0]    num_frames,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [4*In_d_W-1:0] s_data,
    output logic [3:0]          lane_valid,
    output logic [4*In_d_W-1:0] lane_data,
    output logic                lane_clr,
    input  logic [3:0]          pool_valid,
    output logic                busy,
    output logic                frame_done,
    output logic                job_done,
    output logic                err
);

    localparam int IN_N  = in_pix(W);
    localparam int OUT_N = out_pix(W);
    localparam int IC_W  = $clog2(IN_N + 1);
    localparam int OC_W  = $clog2(OUT_N + 1);
    localparam int DT_W  = $clog2(DRAIN_MAX + 1);

    localparam logic [IC_W-1:0] IN_MAX  = IC_W'(IN_N);
    localparam logic [OC_W-1:0] OUT_MAX = OC_W'(OUT_N);
    localparam logic [DT_W-1:0] DT_MAX  = DT_W'(DRAIN_MAX);

    state_t                r_state;
    logic [IC_W-1:0]       r_in_cnt;
    logic [OC_W-1:0]       r_out_cnt;
    logic [DT_W-1:0]       r_dtmr;
    logic [FRM_W-1:0]      r_frm_cnt;
    logic [FRM_W-1:0]      r_nfrm;
    logic                  r_err;
    logic [3:0]            r_lane_valid;
    logic [4*In_d_W-1:0]   r_lane_data;
    logic                  r_lane_clr;
    logic                  r_frame_done;
    logic                  r_job_done;

    state_t                w_state_nxt;
    logic [IC_W-1:0]       w_in_nxt;
    logic [OC_W-1:0]       w_out_nxt;
    logic [DT_W-1:0]       w_dtmr_nxt;
    logic [FRM_W-1:0]      w_frm_nxt;
    logic [FRM_W-1:0]      w_nfrm_nxt;
    logic                  w_err_nxt;
    logic                  w_fire;
    logic                  w_cnt_en;
    logic                  w_pv_all;
    logic                  w_desync;
    logic                  w_out_inc;

    assign s_ready    = (r_state == RUN) && (r_in_cnt < IN_MAX);
    assign busy       = (r_state != IDLE);
    assign lane_valid = r_lane_valid;
    assign lane_data  = r_lane_data;
    assign lane_clr   = r_lane_clr;
    assign frame_done = r_frame_done;
    assign job_done   = r_job_done;
    assign err        = r_err;

    // Partial lane activity means the lanes have slipped relative to each other.
    always_comb begin
        w_fire    = s_valid & s_ready;
        w_cnt_en  = (r_state == RUN) || (r_state == DRAIN);
        w_pv_all  = w_cnt_en && (pool_valid == 4'hF);
        w_desync  = w_cnt_en && (pool_valid != 4'h0)
                    && (pool_valid != 4'hF);
        w_out_inc = w_pv_all && (r_out_cnt < OUT_MAX);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_nxt    = w_fire ? r_in_cnt + 1'b1 : r_in_cnt;
        w_out_nxt   = w_out_inc ? r_out_cnt + 1'b1 : r_out_cnt;
        w_dtmr_nxt  = '0;
        w_frm_nxt   = r_frm_cnt;
        w_nfrm_nxt  = r_nfrm;
        w_err_nxt   = r_err | w_desync;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_in_nxt    = '0;
                    w_out_nxt   = '0;
                    w_frm_nxt   = '0;
                    w_err_nxt   = 1'b0;
                    w_nfrm_nxt  = (num_frames == '0) ? FRM_W'(1)
                                                     : num_frames;
                end
            end
            RUN: begin
                if (w_fire && (w_in_nxt == IN_MAX)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_dtmr_nxt = w_out_inc ? '0 : r_dtmr + 1'b1;
                if (w_out_nxt == OUT_MAX) begin
                    w_state_nxt = FLUSH;
                end else if (w_dtmr_nxt == DT_MAX) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                w_in_nxt  = '0;
                w_out_nxt = '0;
                w_frm_nxt = r_frm_cnt + 1'b1;
                if ((r_frm_cnt + 1'b1) < r_nfrm) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Pulses are decoded from the next state so they align with FLUSH/DONE.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state      <= IDLE;
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_dtmr       <= '0;
            r_frm_cnt    <= '0;
            r_nfrm       <= '0;
            r_err        <= 1'b0;
            r_lane_valid <= 4'h0;
            r_lane_data  <= '0;
            r_lane_clr   <= 1'b0;
            r_frame_done <= 1'b0;
            r_job_done   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_in_cnt     <= w_in_nxt;
            r_out_cnt    <= w_out_nxt;
            r_dtmr       <= w_dtmr_nxt;
            r_frm_cnt    <= w_frm_nxt;
            r_nfrm       <= w_nfrm_nxt;
            r_err        <= w_err_nxt;
            r_lane_valid <= w_fire ? 4'hF : 4'h0;
            if (w_fire) begin
                r_lane_data <= s_data;
            end
            r_lane_clr   <= (w_state_nxt == FLUSH);
            r_frame_done <= (w_state_nxt == FLUSH);
            r_job_done   <= (w_state_nxt == DONE);
        end
    end

endmodule
